// File: rtl/register_file_pkg.sv
// Shared constants and types for the RV64I integer register file.
// The read ports are parameterised separately; these are the defaults used by the top.
package register_file_pkg;

  localparam int WORDSIZE = 64;
  localparam int NREGS    = 32;
  localparam int ADDRW    = 5;

  typedef logic [WORDSIZE-1:0] word_t;
  typedef logic [ADDRW-1:0]    addr_t;

  localparam addr_t ZERO_REG = 5'd0;

  // x0 is hardwired: any access to it neither stores nor returns data.
  function automatic logic is_zero_reg(input addr_t addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Write and read bus of the register file.
// The master side is the datapath (writeback and decode); the slave side is the register file.
interface register_file_if;
  import register_file_pkg::*;

  logic  write_enable;
  addr_t rd_addr;
  word_t rd_data;
  addr_t rs1_addr;
  addr_t rs2_addr;
  word_t rs1_data;
  word_t rs2_data;

  modport master (
    output write_enable, rd_addr, rd_data, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  write_enable, rd_addr, rd_data, rs1_addr, rs2_addr,
    output rs1_data, rs2_data
  );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: x0 forcing, same-cycle write bypass, then an NREGS:1 mux.
// Slot 0 of the flattened storage is ignored because x0 is forced to zero here.
module register_read_port #(
  parameter int WORDSIZE = 64,
  parameter int NREGS    = 32,
  parameter int ADDRW    = 5
) (
  input  logic [NREGS*WORDSIZE-1:0] regs_flat,
  input  logic [ADDRW-1:0]          addr,
  input  logic                      write_enable,
  input  logic [ADDRW-1:0]          rd_addr,
  input  logic [WORDSIZE-1:0]       rd_data,
  input  logic                      reset,
  output logic [WORDSIZE-1:0]       rs_data
);

  logic [WORDSIZE-1:0] words [NREGS];
  logic                addr_is_zero;
  logic                bypass_hit;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
    assign words[gi] = regs_flat[gi*WORDSIZE +: WORDSIZE];
  end

  assign addr_is_zero = (addr == '0);
  // Bypass is blocked during reset so the reader sees the stored value, not the write being discarded.
  assign bypass_hit   = reset && write_enable && (rd_addr == addr);

  always_comb begin
    rs_data = '0;
    if (addr_is_zero) begin
      rs_data = '0;
    end else if (bypass_hit) begin
      rs_data = rd_data;
    end else begin
      rs_data = words[addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit RV64I register file: one synchronous write port, two combinational read ports.
// reset is synchronous and active-low; it clears every register and overrides a pending write.
module register_file
  import register_file_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave bus
);

  word_t                        regs_q [1:NREGS-1];
  word_t                        regs_d [1:NREGS-1];
  logic  [NREGS*WORDSIZE-1:0]   regs_flat;
  logic                         write_valid;

  assign write_valid = bus.write_enable && !is_zero_reg(bus.rd_addr);

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_regs
    always_comb begin
      regs_d[gi] = regs_q[gi];
      if (write_valid && (bus.rd_addr == addr_t'(gi))) begin
        regs_d[gi] = bus.rd_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        regs_q[gi] <= '0;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end

    assign regs_flat[gi*WORDSIZE +: WORDSIZE] = regs_q[gi];
  end

  // x0 has no storage; its slot is tied off and the read ports force it to zero anyway.
  assign regs_flat[WORDSIZE-1:0] = '0;

  register_read_port #(
    .WORDSIZE (WORDSIZE),
    .NREGS    (NREGS),
    .ADDRW    (ADDRW)
  ) u_rs1_port (
    .regs_flat    (regs_flat),
    .addr         (bus.rs1_addr),
    .write_enable (bus.write_enable),
    .rd_addr      (bus.rd_addr),
    .rd_data      (bus.rd_data),
    .reset        (reset),
    .rs_data      (bus.rs1_data)
  );

  register_read_port #(
    .WORDSIZE (WORDSIZE),
    .NREGS    (NREGS),
    .ADDRW    (ADDRW)
  ) u_rs2_port (
    .regs_flat    (regs_flat),
    .addr         (bus.rs2_addr),
    .write_enable (bus.write_enable),
    .rd_addr      (bus.rd_addr),
    .rd_data      (bus.rd_data),
    .reset        (reset),
    .rs_data      (bus.rs2_data)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset scan, writes, x0, bypass, write-disable, reset-vs-write.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam word_t VAL_X5   = 64'h14a7_e226_fc32_92a1;
  localparam word_t VAL_DEAD = 64'hdead_beef_0000_0007;
  localparam word_t VAL_ONES = 64'hffff_ffff_ffff_ffff;
  localparam word_t VAL_X10  = 64'h0123_4567_89ab_cdef;

  task automatic check(input string tag, input word_t observed, input word_t expected);
    compared++;
    assert (observed === expected)
      $display("check %-14s observed=%h expected=%h", tag, observed, expected);
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input addr_t a1, input addr_t a2);
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    bus.rd_addr      = '0;
    bus.rd_data      = '0;
    bus.rs1_addr     = '0;
    bus.rs2_addr     = '0;
    tick();
    tick();
    reset = 1'b1;

    // Reset scan on both ports
    for (int a = 0; a < NREGS; a++) begin
      set_read(addr_t'(a), addr_t'(NREGS - 1 - a));
      check("scan_rs1", bus.rs1_data, 64'h0);
      check("scan_rs2", bus.rs2_data, 64'h0);
    end

    // Plain write to x5
    bus.write_enable = 1'b1;
    bus.rd_addr      = 5'd5;
    bus.rd_data      = VAL_X5;
    tick();
    bus.write_enable = 1'b0;
    set_read(5'd5, 5'd5);
    check("x5_rs1", bus.rs1_data, VAL_X5);
    check("x5_rs2", bus.rs2_data, VAL_X5);
    set_read(5'd4, 5'd6);
    check("x4_zero", bus.rs1_data, 64'h0);
    check("x6_zero", bus.rs2_data, 64'h0);

    // Write to x0 is dropped and x0 reads zero even during the write
    bus.write_enable = 1'b1;
    bus.rd_addr      = 5'd0;
    bus.rd_data      = VAL_ONES;
    set_read(5'd0, 5'd5);
    check("x0_during", bus.rs1_data, 64'h0);
    check("x5_keep", bus.rs2_data, VAL_X5);
    tick();
    bus.write_enable = 1'b0;
    #1;
    check("x0_after", bus.rs1_data, 64'h0);

    // Bypass: x7 holds 1, then overwritten while being read
    bus.write_enable = 1'b1;
    bus.rd_addr      = 5'd7;
    bus.rd_data      = 64'h1;
    tick();
    bus.write_enable = 1'b0;
    set_read(5'd7, 5'd8);
    check("x7_old", bus.rs1_data, 64'h1);
    bus.write_enable = 1'b1;
    bus.rd_addr      = 5'd7;
    bus.rd_data      = VAL_DEAD;
    #1;
    check("bypass_rs1", bus.rs1_data, VAL_DEAD);
    check("bypass_rs2_x8", bus.rs2_data, 64'h0);
    tick();
    bus.write_enable = 1'b0;
    #1;
    check("x7_new", bus.rs1_data, VAL_DEAD);

    // Both ports on the same address share the bypass
    bus.write_enable = 1'b1;
    bus.rd_addr      = 5'd10;
    bus.rd_data      = VAL_X10;
    set_read(5'd10, 5'd10);
    check("byp_same_rs1", bus.rs1_data, VAL_X10);
    check("byp_same_rs2", bus.rs2_data, VAL_X10);
    tick();
    bus.write_enable = 1'b0;
    #1;
    check("x10_stored", bus.rs2_data, VAL_X10);

    // write_enable low leaves x3 untouched
    bus.write_enable = 1'b0;
    bus.rd_addr      = 5'd3;
    bus.rd_data      = VAL_ONES;
    tick();
    set_read(5'd3, 5'd31);
    check("x3_unchanged", bus.rs1_data, 64'h0);
    check("x31_zero", bus.rs2_data, 64'h0);

    // Reset low suppresses bypass: stored value is visible, not the write data
    reset            = 1'b0;
    bus.write_enable = 1'b1;
    bus.rd_addr      = 5'd5;
    bus.rd_data      = 64'h55;
    set_read(5'd9, 5'd5);
    check("rst_nobyp_x5", bus.rs2_data, VAL_X5);
    bus.rd_addr = 5'd9;
    #1;
    check("rst_x9_read", bus.rs1_data, 64'h0);
    tick();
    reset            = 1'b1;
    bus.write_enable = 1'b0;
    set_read(5'd5, 5'd9);
    check("rst_x5_clear", bus.rs1_data, 64'h0);
    check("rst_x9_drop", bus.rs2_data, 64'h0);
    set_read(5'd7, 5'd10);
    check("rst_x7_clear", bus.rs1_data, 64'h0);
    check("rst_x10_clear", bus.rs2_data, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
